// File: rtl/manchester_xmit_frame.sv
// Parametrised Manchester transmitter: word-at-a-time source handshake in,
// Manchester-encoded line (txd/txen) out, with optional preamble and idle tail.
module manchester_xmit_frame #(
  parameter int CLK_RATE      = 100000000,
  parameter int BIT_RATE      = 50000,
  parameter int DATA_WIDTH    = 8,
  parameter int MSB_FIRST     = 0,
  parameter int IEEE_POL      = 0,
  parameter int PREAMBLE_BITS = 8,
  parameter int IDLE_BITS     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  rdy,
  output logic                  txd,
  output logic                  txen,
  output logic                  frame_done
);

  localparam int HALF     = CLK_RATE / (2 * BIT_RATE);
  localparam int TW       = $clog2(HALF) + 1;
  localparam int BW       = $clog2(DATA_WIDTH) + 1;
  localparam int PRE_MAX  = (PREAMBLE_BITS > 0) ? PREAMBLE_BITS : 1;
  localparam int PW       = $clog2(PRE_MAX) + 1;
  localparam int IDLE_CYC = IDLE_BITS * 2 * HALF;
  localparam int IDL_MAX  = (IDLE_CYC > 0) ? IDLE_CYC : 1;
  localparam int IW       = $clog2(IDL_MAX) + 1;

  localparam logic [TW-1:0] HALF_LAST = TW'(HALF - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);
  localparam logic [PW-1:0] PRE_LAST  = PW'(PRE_MAX - 1);
  localparam logic [IW-1:0] IDL_LAST  = IW'(IDL_MAX - 1);
  localparam logic          POL       = (IEEE_POL != 0);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PREAMBLE_A = 3'd1,
    PREAMBLE_B = 3'd2,
    DATA_A     = 3'd3,
    DATA_B     = 3'd4,
    IDLE_TX    = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic [TW-1:0]           tmr_q, tmr_d;
  logic [BW-1:0]           bit_q, bit_d;
  logic [PW-1:0]           pre_q, pre_d;
  logic [IW-1:0]           idl_q, idl_d;
  logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
  logic                    txd_q, txd_d;
  logic                    txen_q, txen_d;
  logic                    frame_done_q, frame_done_d;
  logic                    half_end;
  logic                    pre_bit;
  logic                    dat_bit;

  // Handshake: a word is taken on any clk edge where valid && rdy; rdy is
  // high in IDLE, IDLE_TX and on the final cycle of the last data half-bit.
  // valid without rdy is ignored, nothing is queued.
  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    bit_d    = bit_q;
    pre_d    = pre_q;
    idl_d    = idl_q;
    shreg_d  = shreg_q;
    rdy      = 1'b0;
    half_end = (tmr_q == HALF_LAST);

    case (state_q)
      IDLE, IDLE_TX: begin
        rdy   = 1'b1;
        tmr_d = '0;
        if (valid) begin
          shreg_d = data;
          bit_d   = '0;
          pre_d   = '0;
          idl_d   = '0;
          state_d = (PREAMBLE_BITS > 0) ? PREAMBLE_A : DATA_A;
        end else if (state_q == IDLE_TX) begin
          if (idl_q == IDL_LAST) begin
            idl_d   = '0;
            state_d = IDLE;
          end else begin
            idl_d = idl_q + IW'(1);
          end
        end
      end
      PREAMBLE_A, DATA_A: begin
        tmr_d = half_end ? '0 : tmr_q + TW'(1);
        if (half_end) state_d = (state_q == PREAMBLE_A) ? PREAMBLE_B : DATA_B;
      end
      PREAMBLE_B: begin
        tmr_d = half_end ? '0 : tmr_q + TW'(1);
        if (half_end) begin
          if (pre_q == PRE_LAST) begin
            pre_d   = '0;
            state_d = DATA_A;
          end else begin
            pre_d   = pre_q + PW'(1);
            state_d = PREAMBLE_A;
          end
        end
      end
      DATA_B: begin
        tmr_d = half_end ? '0 : tmr_q + TW'(1);
        if (half_end) begin
          if (bit_q == BIT_LAST) begin
            rdy   = 1'b1;
            bit_d = '0;
            if (valid) begin
              // continuous stream: next word follows with no preamble or gap
              shreg_d = data;
              state_d = DATA_A;
            end else begin
              idl_d   = '0;
              state_d = (IDLE_CYC > 0) ? IDLE_TX : IDLE;
            end
          end else begin
            bit_d   = bit_q + BW'(1);
            shreg_d = (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);
            state_d = DATA_A;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line outputs are computed from next-state values and registered so the
  // line changes exactly on half-bit boundaries without decode glitches.
  always_comb begin
    pre_bit = ~pre_d[0];
    dat_bit = (MSB_FIRST != 0) ? shreg_d[DATA_WIDTH-1] : shreg_d[0];
    case (state_d)
      PREAMBLE_A: txd_d = pre_bit ^ POL;
      PREAMBLE_B: txd_d = ~(pre_bit ^ POL);
      DATA_A:     txd_d = dat_bit ^ POL;
      DATA_B:     txd_d = ~(dat_bit ^ POL);
      default:    txd_d = 1'b1;
    endcase
    txen_d       = (state_d != IDLE);
    frame_done_d = (state_d == IDLE) && (state_q != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      tmr_q        <= '0;
      bit_q        <= '0;
      pre_q        <= '0;
      idl_q        <= '0;
      shreg_q      <= '0;
      txd_q        <= 1'b1;
      txen_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      bit_q        <= bit_d;
      pre_q        <= pre_d;
      idl_q        <= idl_d;
      shreg_q      <= shreg_d;
      txd_q        <= txd_d;
      txen_q       <= txen_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign txd        = txd_q;
  assign txen       = txen_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_manchester_xmit_frame.sv
// Directed bench for manchester_xmit_frame: four configurations share one
// clock and reset, each scenario task checks its own expected line pattern.
module tb_manchester_xmit_frame;

  logic clk;
  logic rst;

  logic        v0, v1, v2, v3;
  logic [7:0]  d0, d1, d2;
  logic [11:0] d3;
  logic        rdy0, txd0, txen0, fd0;
  logic        rdy1, txd1, txen1, fd1;
  logic        rdy2, txd2, txen2, fd2;
  logic        rdy3, txd3, txen3, fd3;

  int total;
  int bad;

  // HALF = 5 everywhere
  manchester_xmit_frame #(.CLK_RATE(100), .BIT_RATE(10), .DATA_WIDTH(8), .MSB_FIRST(0),
    .IEEE_POL(0), .PREAMBLE_BITS(0), .IDLE_BITS(2)) u0 (
    .clk(clk), .rst(rst), .valid(v0), .data(d0),
    .rdy(rdy0), .txd(txd0), .txen(txen0), .frame_done(fd0));

  manchester_xmit_frame #(.CLK_RATE(100), .BIT_RATE(10), .DATA_WIDTH(8), .MSB_FIRST(1),
    .IEEE_POL(1), .PREAMBLE_BITS(0), .IDLE_BITS(2)) u1 (
    .clk(clk), .rst(rst), .valid(v1), .data(d1),
    .rdy(rdy1), .txd(txd1), .txen(txen1), .frame_done(fd1));

  manchester_xmit_frame #(.CLK_RATE(100), .BIT_RATE(10), .DATA_WIDTH(8), .MSB_FIRST(0),
    .IEEE_POL(0), .PREAMBLE_BITS(4), .IDLE_BITS(2)) u2 (
    .clk(clk), .rst(rst), .valid(v2), .data(d2),
    .rdy(rdy2), .txd(txd2), .txen(txen2), .frame_done(fd2));

  manchester_xmit_frame #(.CLK_RATE(100), .BIT_RATE(10), .DATA_WIDTH(12), .MSB_FIRST(0),
    .IEEE_POL(0), .PREAMBLE_BITS(0), .IDLE_BITS(0)) u3 (
    .clk(clk), .rst(rst), .valid(v3), .data(d3),
    .rdy(rdy3), .txd(txd3), .txen(txen3), .frame_done(fd3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    total++; if ({rdy0, txd0, txen0, fd0} !== 4'b1100) begin bad++;
      $display("FAIL reset_u0 got=%b exp=1100", {rdy0, txd0, txen0, fd0}); end
    total++; if ({rdy1, txd1, txen1, fd1} !== 4'b1100) begin bad++;
      $display("FAIL reset_u1 got=%b exp=1100", {rdy1, txd1, txen1, fd1}); end
    total++; if ({rdy2, txd2, txen2, fd2} !== 4'b1100) begin bad++;
      $display("FAIL reset_u2 got=%b exp=1100", {rdy2, txd2, txen2, fd2}); end
    total++; if ({rdy3, txd3, txen3, fd3} !== 4'b1100) begin bad++;
      $display("FAIL reset_u3 got=%b exp=1100", {rdy3, txd3, txen3, fd3}); end
  endtask

  // 0xA5 LSB first, normal polarity
  task automatic test_lsb_a5();
    logic [15:0] exp;
    exp = 16'h9966;
    v0 = 1'b1; d0 = 8'hA5;
    for (int c = 1; c <= 102; c++) begin
      @(negedge clk);
      v0 = 1'b0; d0 = 8'h00;
      if (c <= 80) begin
        total++; if (txd0 !== exp[15 - (c - 1) / 5]) begin bad++;
          $display("FAIL lsb_txd c=%0d got=%b exp=%b", c, txd0, exp[15 - (c - 1) / 5]); end
        total++; if (rdy0 !== (c == 80)) begin bad++;
          $display("FAIL lsb_rdy c=%0d got=%b exp=%b", c, rdy0, (c == 80)); end
        total++; if (txen0 !== 1'b1) begin bad++;
          $display("FAIL lsb_txen c=%0d got=%b exp=1", c, txen0); end
      end else if (c <= 100) begin
        total++; if ({txd0, txen0, rdy0, fd0} !== 4'b1110) begin bad++;
          $display("FAIL lsb_tail c=%0d got=%b exp=1110", c, {txd0, txen0, rdy0, fd0}); end
      end else begin
        total++; if ({txd0, txen0, fd0} !== {1'b1, 1'b0, (c == 101)}) begin bad++;
          $display("FAIL lsb_done c=%0d got=%b exp=10%b", c, {txd0, txen0, fd0}, (c == 101)); end
      end
    end
  endtask

  // 0x80 MSB first, IEEE polarity
  task automatic test_msb_ieee();
    logic [15:0] exp;
    exp = 16'h6AAA;
    v1 = 1'b1; d1 = 8'h80;
    for (int c = 1; c <= 102; c++) begin
      @(negedge clk);
      v1 = 1'b0; d1 = 8'h00;
      if (c <= 80) begin
        total++; if ({txd1, txen1} !== {exp[15 - (c - 1) / 5], 1'b1}) begin bad++;
          $display("FAIL msb_line c=%0d got=%b exp=%b1", c, {txd1, txen1}, exp[15 - (c - 1) / 5]); end
      end else if (c <= 100) begin
        total++; if ({txd1, txen1, fd1} !== 3'b110) begin bad++;
          $display("FAIL msb_tail c=%0d got=%b exp=110", c, {txd1, txen1, fd1}); end
      end else begin
        total++; if ({txen1, fd1} !== {1'b0, (c == 101)}) begin bad++;
          $display("FAIL msb_done c=%0d got=%b exp=0%b", c, {txen1, fd1}, (c == 101)); end
      end
    end
  endtask

  // 4 preamble bits then 0x00
  task automatic test_preamble();
    logic [23:0] exp;
    exp = 24'h995555;
    v2 = 1'b1; d2 = 8'h00;
    for (int c = 1; c <= 142; c++) begin
      @(negedge clk);
      v2 = 1'b0;
      if (c <= 120) begin
        total++; if (txd2 !== exp[23 - (c - 1) / 5]) begin bad++;
          $display("FAIL pre_txd c=%0d got=%b exp=%b", c, txd2, exp[23 - (c - 1) / 5]); end
        total++; if ({rdy2, txen2} !== {(c == 120), 1'b1}) begin bad++;
          $display("FAIL pre_rdy c=%0d got=%b exp=%b1", c, {rdy2, txen2}, (c == 120)); end
      end else begin
        total++; if ({txen2, fd2} !== {(c <= 140), (c == 141)}) begin bad++;
          $display("FAIL pre_tail c=%0d got=%b exp=%b%b", c, {txen2, fd2}, (c <= 140), (c == 141)); end
      end
    end
  endtask

  // new word during idle tail restarts with a preamble, no frame_done
  task automatic test_idle_abort();
    logic [23:0] exp;
    exp = 24'h99AAAA;
    v2 = 1'b1; d2 = 8'h00;
    for (int c = 1; c <= 127; c++) begin
      @(negedge clk);
      v2 = 1'b0;
      total++; if (fd2 !== 1'b0) begin bad++;
        $display("FAIL abort_fd_first c=%0d got=%b exp=0", c, fd2); end
    end
    total++; if ({rdy2, txd2, txen2} !== 3'b111) begin bad++;
      $display("FAIL abort_tail_state got=%b exp=111", {rdy2, txd2, txen2}); end
    v2 = 1'b1; d2 = 8'hFF;
    for (int c = 1; c <= 142; c++) begin
      @(negedge clk);
      v2 = 1'b0;
      if (c <= 120) begin
        total++; if ({txd2, txen2} !== {exp[23 - (c - 1) / 5], 1'b1}) begin bad++;
          $display("FAIL abort_line c=%0d got=%b exp=%b1", c, {txd2, txen2}, exp[23 - (c - 1) / 5]); end
      end
      total++; if (fd2 !== (c == 141)) begin bad++;
        $display("FAIL abort_fd c=%0d got=%b exp=%b", c, fd2, (c == 141)); end
    end
  endtask

  // valid held high: 0x0F then 0xF0 as one continuous frame
  task automatic test_back_to_back();
    logic [31:0] exp;
    int          fd_count;
    exp = 32'hAA5555AA;
    fd_count = 0;
    v0 = 1'b1; d0 = 8'h0F;
    for (int c = 1; c <= 185; c++) begin
      @(negedge clk);
      v0 = (c <= 80);
      d0 = 8'hF0;
      if (fd0 === 1'b1) fd_count++;
      if (c <= 160) begin
        total++; if ({txd0, txen0} !== {exp[31 - (c - 1) / 5], 1'b1}) begin bad++;
          $display("FAIL b2b_line c=%0d got=%b exp=%b1", c, {txd0, txen0}, exp[31 - (c - 1) / 5]); end
        total++; if (rdy0 !== (c == 80 || c == 160)) begin bad++;
          $display("FAIL b2b_rdy c=%0d got=%b exp=%b", c, rdy0, (c == 80 || c == 160)); end
      end
      total++; if (fd0 !== (c == 181)) begin bad++;
        $display("FAIL b2b_fd c=%0d got=%b exp=%b", c, fd0, (c == 181)); end
    end
    total++; if (fd_count != 1) begin bad++;
      $display("FAIL b2b_fd_count got=%0d exp=1", fd_count); end
  endtask

  // rst during data bit 3 kills the frame at once
  task automatic test_rst_abort();
    v0 = 1'b1; d0 = 8'h00;
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      v0 = 1'b0;
      total++; if (txd0 !== (((c - 1) / 5) % 2 == 1)) begin bad++;
        $display("FAIL rsta_txd c=%0d got=%b exp=%b", c, txd0, (((c - 1) / 5) % 2 == 1)); end
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if ({txen0, txd0, rdy0, fd0} !== 4'b0110) begin bad++;
      $display("FAIL rsta_outputs got=%b exp=0110", {txen0, txd0, rdy0, fd0}); end
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      total++; if ({txen0, fd0} !== 2'b00) begin bad++;
        $display("FAIL rsta_quiet c=%0d got=%b exp=00", c, {txen0, fd0}); end
    end
  endtask

  // 12-bit word, no idle tail
  task automatic test_width12();
    logic [23:0] exp;
    exp = 24'h5AA666;
    v3 = 1'b1; d3 = 12'hABC;
    for (int c = 1; c <= 122; c++) begin
      @(negedge clk);
      v3 = 1'b0;
      if (c <= 120) begin
        total++; if ({txd3, txen3, rdy3, fd3} !== {exp[23 - (c - 1) / 5], 1'b1, (c == 120), 1'b0}) begin bad++;
          $display("FAIL w12_line c=%0d got=%b exp=%b1%b0", c, {txd3, txen3, rdy3, fd3}, exp[23 - (c - 1) / 5], (c == 120)); end
      end else begin
        total++; if ({txd3, txen3, rdy3, fd3} !== {3'b101, (c == 121)}) begin bad++;
          $display("FAIL w12_end c=%0d got=%b exp=101%b", c, {txd3, txen3, rdy3, fd3}, (c == 121)); end
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0; v3 = 1'b0;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;
    rst = 1'b1;
    test_reset();
    test_lsb_a5();
    test_msb_ieee();
    test_preamble();
    test_idle_abort();
    test_back_to_back();
    test_rst_abort();
    test_width12();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/manchester_xmit_frame.md
Name: manchester_xmit_frame

Overview:
Parametrised Manchester transmitter, successor to the team's fixed 8-bit transmitter. Adds:
- configurable word width and bit order
- selectable encoding polarity
- optional alternating preamble at frame start
- internal half-bit timing derived from clock and bit rates
- frame-done pulse

Sits between a byte/word source (valid/rdy handshake) and the line driver (txd/txen).

Parameters:
CLK_RATE, 100000000, system clock frequency in Hz
BIT_RATE, 50000, line bit rate in bit/s; HALF = CLK_RATE/(2*BIT_RATE) cycles per half-bit, must be >= 2
DATA_WIDTH, 8, bits per word, >= 1
MSB_FIRST, 0, 0 = LSB transmitted first, 1 = MSB first
IEEE_POL, 0, 0 = bit b sends b in first half then ~b; 1 = sends ~b then b (IEEE 802.3)
PREAMBLE_BITS, 8, Manchester-encoded bits of pattern 1,0,1,0,... sent before first word of a frame; 0 disables
IDLE_BITS, 2, full bit times of txd=1/txen=1 after last word of a frame; 0 = straight to IDLE

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
valid  input  1  source has a word on data
data  input  DATA_WIDTH  word to send, sampled only on acceptance
rdy  output  1  block can accept a word this cycle
txd  output  1  Manchester line data
txen  output  1  line driver enable
frame_done  output  1  one-cycle pulse when frame ends (entering IDLE)

Behaviour:
- Clock/reset: single clock clk; reset rst is synchronous and active-high.
- After reset (first cycle rst low): state IDLE, rdy=1, txd=1, txen=0, frame_done=0. Bit/half-bit/preamble/idle counters = 0; shift register = 0.
- Acceptance: valid && rdy on a clk edge. data is loaded into the shift register and the half-bit timer is restarted. valid while rdy=0 is ignored; there is no queueing.
- States: IDLE, PREAMBLE_A, PREAMBLE_B, DATA_A, DATA_B, IDLE_TX. Suffix A = first half of a bit, B = second half. Every A/B state lasts exactly HALF cycles.
- IDLE: rdy=1, txen=0, txd=1. On acceptance -> PREAMBLE_A if PREAMBLE_BITS>0, else DATA_A. txen=1 from the next cycle.
- PREAMBLE_A/B: preamble bit p (p=0..PREAMBLE_BITS-1) has value ~p[0], encoded per IEEE_POL. After the B half of the last preamble bit -> DATA_A.
- DATA_A/B: current bit is shreg[0] (LSB first) or shreg[DATA_WIDTH-1] (MSB first); first half per IEEE_POL, second half inverted. The register shifts at end of each B half.
- Last data bit, final cycle of its B half: rdy=1 for exactly that cycle.
  - If valid: new word loaded, -> DATA_A. No preamble, no gap; the line stays continuous.
  - Else -> IDLE_TX, or -> IDLE with frame_done if IDLE_BITS=0.
- IDLE_TX: txd=1, txen=1, rdy=1. Lasts IDLE_BITS*2*HALF cycles, then -> IDLE with frame_done=1 on the transition cycle.
  - Acceptance during IDLE_TX aborts the tail and starts a new frame (with preamble) exactly as from IDLE. frame_done is not pulsed in that case.
- Counters:
  - bit counter wraps DATA_WIDTH-1 -> 0
  - half-bit timer 0..HALF-1
  - all counters sized by $clog2 of their maximum, plus 1 bit
- rst asserted mid-transmission: aborts immediately. Next cycle outputs are at reset values (txen=0, txd=1). No frame_done.
- txd and txen are registered or derived glitch-free from state. Timing is relative to acceptance: first txd half-bit begins the cycle after acceptance.

Test Plan:
- CLK_RATE=100, BIT_RATE=10 (HALF=5), DATA_WIDTH=8, LSB first, IEEE_POL=0, PREAMBLE_BITS=0, IDLE_BITS=2; send 0xA5 -> txd per half-bit: 1,0,0,1,1,0,0,1,0,1,1,0,0,1,1,0, each 5 cycles. Then txd=1/txen=1 for 20 cycles, frame_done pulse, txen=0.
- Same config with MSB_FIRST=1, IEEE_POL=1; send 0x80 -> first bit halves 0,1, then seven bits each 1,0. Total 80 cycles of txen=1 before the idle tail.
- PREAMBLE_BITS=4, word 0x00 -> halves 1,0,0,1,1,0,0,1 (preamble), then 0,1 repeated 8 times. rdy stays low throughout the frame until the last cycle.
- Back-to-back: valid held high with 0x0F then 0xF0 -> rdy high exactly one cycle at cycle 80 after first acceptance. Second word starts with no preamble and no gap; a single frame_done at the end.
- Abort/restart: valid during IDLE_TX cycle 7 -> new preamble starts the next cycle, no frame_done. Separately, rst at data bit 3 -> next cycle txen=0, txd=1, rdy=1.
- DATA_WIDTH=12, IDLE_BITS=0; send 0xABC -> 24 half-bits, then straight to IDLE with frame_done the cycle after the last half-bit ends.
